// File: rtl/vga_rd_sched.sv
// vga_rd_sched: read-side burst scheduler for the VGA display path.
// Keeps the pixel FIFO topped up with burst reads from the frame buffer,
// generates frame addresses, trims the final burst of a frame to the
// remaining word count and selects the ping-pong display buffer.
// Optional feature macro: VGA_RD_SCHED_UFCNT_EN adds a saturating
// underflow event counter output (underflow_cnt).
module vga_rd_sched #(
  parameter int unsigned H_ACT      = 640,
  parameter int unsigned V_ACT      = 480,
  parameter int unsigned BURST_LEN  = 64,
  parameter int unsigned FIFO_DEPTH = 512,
  parameter logic [23:0] BUF0_BASE  = 24'h00_0000,
  parameter logic [23:0] BUF1_BASE  = 24'h08_0000
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic        frame_start,
  input  logic        pix_data_req,
  input  logic        fifo_empty,
  input  logic [9:0]  fifo_level,
  input  logic        wr_frame_done,
  input  logic        wr_buf,
  output logic        rd_req,
  output logic [23:0] rd_addr,
  output logic [7:0]  rd_len,
  input  logic        rd_ack,
  input  logic        rd_done,
  output logic        fifo_clr,
  output logic        rd_buf,
`ifdef VGA_RD_SCHED_UFCNT_EN
  output logic [15:0] underflow_cnt,
`endif
  output logic        underflow
);

  localparam logic [18:0] FRAME_WORDS = 19'(H_ACT * V_ACT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_CHECK = 3'd2,
    S_REQ   = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [23:0] addr;
  logic [18:0] words_left;
  logic        rdy;
  logic        nxt_buf;
  logic        pend_fs;
  logic [10:0] level_sum;
  logic        fifo_room;
  logic [7:0]  burst_len;
  logic        flush_buf;
  logic        uf_event;

  // Burst sizing, FIFO headroom test and buffer chosen at the next flush.
  always_comb begin
    level_sum = {1'b0, fifo_level} + 11'(BURST_LEN);
    fifo_room = (level_sum <= 11'(FIFO_DEPTH));
    if (words_left < 19'(BURST_LEN)) begin
      burst_len = words_left[7:0];
    end else begin
      burst_len = 8'(BURST_LEN);
    end
    flush_buf = rdy ? nxt_buf : rd_buf;
    uf_event  = pix_data_req & fifo_empty;
  end

  // Next-state logic for the burst scheduling FSM.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (frame_start) state_nxt = S_FLUSH;
        else             state_nxt = S_IDLE;
      end
      S_FLUSH: state_nxt = S_CHECK;
      S_CHECK: begin
        if (frame_start)            state_nxt = S_FLUSH;
        else if (words_left == '0)  state_nxt = S_DONE;
        else if (fifo_room)         state_nxt = S_REQ;
        else                        state_nxt = S_CHECK;
      end
      S_REQ: begin
        if (rd_ack) state_nxt = S_WAIT;
        else        state_nxt = S_REQ;
      end
      S_WAIT: begin
        if (rd_done) state_nxt = (pend_fs || frame_start) ? S_FLUSH : S_CHECK;
        else         state_nxt = S_WAIT;
      end
      S_DONE: begin
        if (frame_start) state_nxt = S_FLUSH;
        else             state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register plus registered request/flush strobes.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= S_IDLE;
      rd_req   <= 1'b0;
      fifo_clr <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_req   <= (state_nxt == S_REQ);
      fifo_clr <= (state_nxt == S_FLUSH);
    end
  end

  // Address/word tracking, burst descriptor and pending frame-start flag.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      addr       <= 24'h00_0000;
      words_left <= 19'd0;
      rd_addr    <= 24'h00_0000;
      rd_len     <= 8'd0;
      rd_buf     <= 1'b0;
      pend_fs    <= 1'b0;
    end else begin
      case (state)
        S_FLUSH: begin
          rd_buf     <= flush_buf;
          addr       <= flush_buf ? BUF1_BASE : BUF0_BASE;
          words_left <= FRAME_WORDS;
          pend_fs    <= 1'b0;
        end
        S_CHECK: begin
          if (state_nxt == S_REQ) begin
            rd_addr <= addr;
            rd_len  <= burst_len;
          end
        end
        S_REQ: begin
          if (frame_start) pend_fs <= 1'b1;
        end
        S_WAIT: begin
          if (frame_start) pend_fs <= 1'b1;
          if (rd_done) begin
            addr       <= addr + {16'd0, rd_len};
            words_left <= words_left - {11'd0, rd_len};
          end
        end
        default: begin
          pend_fs <= pend_fs;
        end
      endcase
    end
  end

  // Ready tracking: a writer completion stays pending across a coincident flush.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rdy     <= 1'b0;
      nxt_buf <= 1'b0;
    end else if (wr_frame_done) begin
      rdy     <= 1'b1;
      nxt_buf <= wr_buf;
    end else if (state == S_FLUSH) begin
      rdy     <= 1'b0;
    end else begin
      rdy     <= rdy;
    end
  end

  // Sticky underflow flag; the flush clear takes priority over a new event.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      underflow <= 1'b0;
    end else if (state == S_FLUSH) begin
      underflow <= 1'b0;
    end else if (uf_event) begin
      underflow <= 1'b1;
    end else begin
      underflow <= underflow;
    end
  end

`ifdef VGA_RD_SCHED_UFCNT_EN
  // Saturating underflow event counter, cleared at each flush.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      underflow_cnt <= 16'd0;
    end else if (state == S_FLUSH) begin
      underflow_cnt <= 16'd0;
    end else if (uf_event && (underflow_cnt != 16'hFFFF)) begin
      underflow_cnt <= underflow_cnt + 16'd1;
    end else begin
      underflow_cnt <= underflow_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_vga_rd_sched.sv
// Directed self-checking bench for vga_rd_sched (default 640x480 instance
// plus a 10x10 instance that exercises the shortened final burst).
module tb_vga_rd_sched;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic        frame_start, pix_data_req, fifo_empty, wr_frame_done, wr_buf;
  logic [9:0]  fifo_level;
  logic        rd_req, rd_ack, rd_done, fifo_clr, rd_buf, underflow;
  logic [23:0] rd_addr;
  logic [7:0]  rd_len;

  logic        s_frame_start, s_rd_req, s_rd_ack, s_rd_done, s_fifo_clr, s_rd_buf, s_underflow;
  logic [23:0] s_rd_addr;
  logic [7:0]  s_rd_len;
`ifdef VGA_RD_SCHED_UFCNT_EN
  logic [15:0] underflow_cnt, s_underflow_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vga_rd_sched dut (
    .vga_clk(clk), .sys_rst_n(sys_rst_n), .frame_start(frame_start),
    .pix_data_req(pix_data_req), .fifo_empty(fifo_empty), .fifo_level(fifo_level),
    .wr_frame_done(wr_frame_done), .wr_buf(wr_buf), .rd_req(rd_req),
    .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack), .rd_done(rd_done),
    .fifo_clr(fifo_clr), .rd_buf(rd_buf),
`ifdef VGA_RD_SCHED_UFCNT_EN
    .underflow_cnt(underflow_cnt),
`endif
    .underflow(underflow)
  );

  vga_rd_sched #(.H_ACT(10), .V_ACT(10), .BURST_LEN(64)) u_small (
    .vga_clk(clk), .sys_rst_n(sys_rst_n), .frame_start(s_frame_start),
    .pix_data_req(1'b0), .fifo_empty(1'b0), .fifo_level(10'd0),
    .wr_frame_done(1'b0), .wr_buf(1'b0), .rd_req(s_rd_req),
    .rd_addr(s_rd_addr), .rd_len(s_rd_len), .rd_ack(s_rd_ack), .rd_done(s_rd_done),
    .fifo_clr(s_fifo_clr), .rd_buf(s_rd_buf),
`ifdef VGA_RD_SCHED_UFCNT_EN
    .underflow_cnt(s_underflow_cnt),
`endif
    .underflow(s_underflow)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Acknowledge the current request together with a frame_start, then complete it.
  task automatic burst_with_fs;
    frame_start = 1'b1; rd_ack = 1'b1;
    tick;
    frame_start = 1'b0; rd_ack = 1'b0; rd_done = 1'b1;
    tick;
    rd_done = 1'b0;
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    frame_start = 1'b0; pix_data_req = 1'b0; fifo_empty = 1'b0; fifo_level = 10'd0;
    wr_frame_done = 1'b0; wr_buf = 1'b0; rd_ack = 1'b0; rd_done = 1'b0;
    s_frame_start = 1'b0; s_rd_ack = 1'b0; s_rd_done = 1'b0;
    tick; tick;
    n_cmp++; if ({rd_req, fifo_clr, rd_buf, underflow} !== 4'b0000) begin n_err++;
      $display("FAIL reset_flags: got %b expected 0000", {rd_req, fifo_clr, rd_buf, underflow}); end
    n_cmp++; if ({rd_addr, rd_len} !== 32'h0) begin n_err++;
      $display("FAIL reset_addr_len: got %h expected 00000000", {rd_addr, rd_len}); end
    sys_rst_n = 1'b1;
    tick;
  endtask

  task automatic test_first_burst;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    n_cmp++; if (fifo_clr !== 1'b1) begin n_err++;
      $display("FAIL first_clr: got %b expected 1", fifo_clr); end
    tick;
    n_cmp++; if ({fifo_clr, rd_req} !== 2'b00) begin n_err++;
      $display("FAIL first_check: got %b expected 00", {fifo_clr, rd_req}); end
    tick;
    n_cmp++; if (rd_req !== 1'b1 || rd_addr !== 24'h000000 || rd_len !== 8'd64) begin n_err++;
      $display("FAIL first_req: got req=%b addr=%h len=%0d expected 1 000000 64", rd_req, rd_addr, rd_len); end
  endtask

  task automatic test_full_frame;
    int bursts = 0;
    int drop_err = 0;
    int late_req = 0;
    logic [23:0] last_addr = 24'h0;
    logic [7:0]  last_len = 8'h0;
    for (int cyc = 0; cyc < 20000 && bursts < 4800; cyc++) begin
      if (rd_req) begin
        last_addr = rd_addr; last_len = rd_len; bursts++;
        rd_ack = 1'b1;
        tick;
        rd_ack = 1'b0;
        if (rd_req !== 1'b0) drop_err++;
        rd_done = 1'b1;
        tick;
        rd_done = 1'b0;
      end else begin
        tick;
      end
    end
    n_cmp++; if (bursts != 4800) begin n_err++;
      $display("FAIL frame_bursts: got %0d expected 4800", bursts); end
    n_cmp++; if (last_addr !== 24'h04AFC0 || last_len !== 8'd64) begin n_err++;
      $display("FAIL frame_last: got addr=%h len=%0d expected 04afc0 64", last_addr, last_len); end
    n_cmp++; if (drop_err != 0) begin n_err++;
      $display("FAIL req_drop: got %0d late drops expected 0", drop_err); end
    for (int i = 0; i < 6; i++) begin
      if (rd_req) late_req++;
      tick;
    end
    n_cmp++; if (late_req != 0 || rd_req !== 1'b0) begin n_err++;
      $display("FAIL frame_done_idle: got %0d extra req cycles expected 0", late_req); end
  endtask

  task automatic test_fifo_room;
    int early = 0;
    fifo_level = 10'd449;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (rd_req) early++;
    end
    n_cmp++; if (early != 0) begin n_err++;
      $display("FAIL fifo_full_hold: got %0d req cycles expected 0", early); end
    fifo_level = 10'd448;
    tick;
    n_cmp++; if (rd_req !== 1'b1 || rd_addr !== 24'h000000) begin n_err++;
      $display("FAIL fifo_room_req: got req=%b addr=%h expected 1 000000", rd_req, rd_addr); end
  endtask

  task automatic test_pend_fs;
    tick;
    n_cmp++; if (rd_req !== 1'b1 || rd_addr !== 24'h000000) begin n_err++;
      $display("FAIL req_hold: got req=%b addr=%h expected 1 000000", rd_req, rd_addr); end
    rd_ack = 1'b1;
    tick;
    rd_ack = 1'b0;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    n_cmp++; if (fifo_clr !== 1'b0) begin n_err++;
      $display("FAIL pend_no_clr: got %b expected 0", fifo_clr); end
    tick;
    n_cmp++; if (fifo_clr !== 1'b0) begin n_err++;
      $display("FAIL pend_wait_done: got %b expected 0", fifo_clr); end
    rd_done = 1'b1;
    tick;
    rd_done = 1'b0;
    n_cmp++; if (fifo_clr !== 1'b1 || rd_req !== 1'b0) begin n_err++;
      $display("FAIL pend_clr: got clr=%b req=%b expected 1 0", fifo_clr, rd_req); end
    tick; tick;
    n_cmp++; if (rd_req !== 1'b1 || rd_addr !== 24'h000000 || rd_len !== 8'd64) begin n_err++;
      $display("FAIL pend_restart: got req=%b addr=%h len=%0d expected 1 000000 64", rd_req, rd_addr, rd_len); end
  endtask

  task automatic test_buf_switch;
    wr_frame_done = 1'b1; wr_buf = 1'b1;
    tick;
    wr_frame_done = 1'b0; wr_buf = 1'b0;
    n_cmp++; if (rd_buf !== 1'b0 || rd_req !== 1'b1) begin n_err++;
      $display("FAIL buf_before: got buf=%b req=%b expected 0 1", rd_buf, rd_req); end
    burst_with_fs;
    tick;
    n_cmp++; if (rd_buf !== 1'b1) begin n_err++;
      $display("FAIL buf_switch: got %b expected 1", rd_buf); end
    tick;
    n_cmp++; if (rd_req !== 1'b1 || rd_addr !== 24'h080000) begin n_err++;
      $display("FAIL buf1_addr: got req=%b addr=%h expected 1 080000", rd_req, rd_addr); end
    burst_with_fs;
    wr_frame_done = 1'b1; wr_buf = 1'b0;
    tick;
    wr_frame_done = 1'b0;
    n_cmp++; if (rd_buf !== 1'b1) begin n_err++;
      $display("FAIL buf_repeat: got %b expected 1", rd_buf); end
    tick;
    n_cmp++; if (rd_req !== 1'b1 || rd_addr !== 24'h080000) begin n_err++;
      $display("FAIL buf_repeat_addr: got req=%b addr=%h expected 1 080000", rd_req, rd_addr); end
    burst_with_fs;
    tick;
    n_cmp++; if (rd_buf !== 1'b0) begin n_err++;
      $display("FAIL buf_pending_used: got %b expected 0", rd_buf); end
    tick;
  endtask

  task automatic test_underflow;
    pix_data_req = 1'b1; fifo_empty = 1'b0;
    tick;
    n_cmp++; if (underflow !== 1'b0) begin n_err++;
      $display("FAIL uf_not_empty: got %b expected 0", underflow); end
    for (int i = 0; i < 3; i++) begin
      pix_data_req = 1'b1; fifo_empty = 1'b1;
      tick;
      pix_data_req = 1'b0; fifo_empty = 1'b0;
      tick;
    end
    n_cmp++; if (underflow !== 1'b1) begin n_err++;
      $display("FAIL uf_set: got %b expected 1", underflow); end
`ifdef VGA_RD_SCHED_UFCNT_EN
    n_cmp++; if (underflow_cnt !== 16'd3) begin n_err++;
      $display("FAIL uf_cnt: got %0d expected 3", underflow_cnt); end
`endif
    burst_with_fs;
    n_cmp++; if (fifo_clr !== 1'b1) begin n_err++;
      $display("FAIL uf_flush: got %b expected 1", fifo_clr); end
    pix_data_req = 1'b1; fifo_empty = 1'b1;
    tick;
    pix_data_req = 1'b0; fifo_empty = 1'b0;
    n_cmp++; if (underflow !== 1'b0) begin n_err++;
      $display("FAIL uf_clear: got %b expected 0", underflow); end
`ifdef VGA_RD_SCHED_UFCNT_EN
    n_cmp++; if (underflow_cnt !== 16'd0) begin n_err++;
      $display("FAIL uf_cnt_clear: got %0d expected 0", underflow_cnt); end
`endif
  endtask

  task automatic test_short_burst;
    int nb = 0;
    logic [23:0] addr_q [4];
    logic [7:0]  len_q [4];
    s_frame_start = 1'b1;
    tick;
    s_frame_start = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (s_rd_req && nb < 4) begin
        addr_q[nb] = s_rd_addr; len_q[nb] = s_rd_len; nb++;
        s_rd_ack = 1'b1;
        tick;
        s_rd_ack = 1'b0; s_rd_done = 1'b1;
        tick;
        s_rd_done = 1'b0;
      end else begin
        tick;
      end
    end
    n_cmp++; if (nb != 2) begin n_err++;
      $display("FAIL short_count: got %0d expected 2", nb); end
    if (nb >= 2) begin
      n_cmp++; if (addr_q[0] !== 24'h0 || len_q[0] !== 8'd64) begin n_err++;
        $display("FAIL short_b0: got addr=%h len=%0d expected 000000 64", addr_q[0], len_q[0]); end
      n_cmp++; if (addr_q[1] !== 24'h000040 || len_q[1] !== 8'd36) begin n_err++;
        $display("FAIL short_b1: got addr=%h len=%0d expected 000040 36", addr_q[1], len_q[1]); end
    end
  endtask

  initial begin
    test_reset;
    test_short_burst;
    test_first_burst;
    test_full_frame;
    test_fifo_room;
    test_pend_fs;
    test_buf_switch;
    test_underflow;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_rd_sched.md
Name: vga_rd_sched

Overview:
Read-side scheduler for the VGA display path. It issues burst read requests to the frame-buffer memory arbiter so that the pixel FIFO feeding the VGA timing generator stays filled ahead of display. It generates frame addresses, keeps the last burst of a frame inside the frame, and selects the ping-pong frame buffer. Sits between the VGA timing generator, the pixel FIFO (vga_clk read side) and the SDRAM arbiter read port.

Parameters:
H_ACT, 640, active pixels per line
V_ACT, 480, active lines per frame
BURST_LEN, 64, max words per read burst (1..255)
FIFO_DEPTH, 512, pixel FIFO capacity in words
BUF0_BASE, 24'h00_0000, word base address of buffer 0
BUF1_BASE, 24'h08_0000, word base address of buffer 1

Ports:
vga_clk  in  1  pixel clock
sys_rst_n  in  1  async active-low reset
frame_start  in  1  one-cycle pulse at start of vertical sync
pix_data_req  in  1  timing generator is popping a pixel this cycle
fifo_empty  in  1  pixel FIFO empty
fifo_level  in  10  pixel FIFO occupancy in words
wr_frame_done  in  1  one-cycle pulse: writer finished a frame (already synced to vga_clk)
wr_buf  in  1  buffer index the writer just completed
rd_req  out  1  burst read request to arbiter
rd_addr  out  24  burst start word address
rd_len  out  8  burst length in words
rd_ack  in  1  one-cycle grant pulse from arbiter
rd_done  in  1  one-cycle pulse: last word of burst written into FIFO
fifo_clr  out  1  synchronous FIFO flush pulse
rd_buf  out  1  buffer currently being displayed
underflow  out  1  sticky: pop attempted while FIFO empty

Behaviour:
- Clock and reset: vga_clk; reset sys_rst_n, asynchronous, active-low.
- Reset values: rd_req=0, rd_addr=0, rd_len=0, fifo_clr=0, rd_buf=0, underflow=0; state IDLE.
- FRAME_WORDS = H_ACT*V_ACT. words_left is 19 bits.
- Ready tracking:
  - wr_frame_done sets rdy=1 and latches nxt_buf=wr_buf.
  - rdy is cleared when it is consumed at FLUSH.
- States:
  - IDLE: wait for frame_start, then FLUSH.
  - FLUSH (1 cycle):
    - fifo_clr=1.
    - If rdy, rd_buf<=nxt_buf and rdy<=0; otherwise rd_buf is held, repeating the frame.
    - addr<=base(rd_buf after update); words_left<=FRAME_WORDS; underflow<=0. Go to CHECK.
  - CHECK:
    - words_left==0: go to DONE.
    - Else if fifo_level+BURST_LEN<=FIFO_DEPTH: load rd_addr=addr, rd_len=min(BURST_LEN,words_left), go to REQ.
    - Else stay in CHECK.
  - REQ:
    - rd_req=1, with rd_addr and rd_len held stable until rd_ack.
    - rd_req drops in the cycle after rd_ack; go to WAIT.
    - A request is never withdrawn.
  - WAIT:
    - On rd_done: addr+=rd_len, words_left-=rd_len.
    - Then FLUSH if pend_fs, else CHECK.
  - DONE: on frame_start go to FLUSH.
- Latency: frame_start to fifo_clr is 1 cycle; FLUSH to first rd_req is 2 cycles when the FIFO has room.
- frame_start in CHECK or DONE: go to FLUSH next cycle.
- frame_start in REQ or WAIT: set pend_fs; the burst completes, then FLUSH; pend_fs is cleared in FLUSH.
- Simultaneous wr_frame_done and FLUSH: the new wr_buf is not used this frame. rdy=1 with nxt_buf=wr_buf remains pending for the next FLUSH.
- rd_ack outside REQ and rd_done outside WAIT are ignored.
- Underflow: pix_data_req && fifo_empty sets underflow. Priority: FLUSH clear wins over set.
- Last burst is shortened to words_left; no address wraps past the buffer end.
- Reset mid-burst returns immediately to IDLE with all outputs at reset values.

Optional Feature:
VGA_RD_SCHED_UFCNT_EN:
- Defined: adds output underflow_cnt[15:0], saturating at 16'hFFFF. It increments on each underflow event and clears in FLUSH; if a clear and an increment coincide, it becomes 0.
- Undefined: the port and counter are absent; only the sticky underflow flag exists.

Test Plan:
- Reset, then frame_start with fifo_level=0 -> fifo_clr pulse at +1; rd_req=1, rd_addr=24'h000000, rd_len=64 at +2.
- Continuous ack/done, fifo_level held 0 -> 4800 bursts; last rd_addr=24'h04AFC0; then DONE with rd_req=0.
- H_ACT=10, V_ACT=10, BURST_LEN=64 -> bursts of len 64 then 36; words_left reaches 0.
- fifo_level=449 -> stays in CHECK, no rd_req; drop to 448 -> rd_req asserted next cycle.
- wr_frame_done with wr_buf=1, then frame_start -> rd_buf=1, rd_addr=24'h080000. Next frame_start without wr_frame_done -> rd_buf stays 1.
- frame_start during WAIT -> burst completes on rd_done, then fifo_clr. pix_data_req with fifo_empty=1 -> underflow=1, cleared at the next FLUSH; underflow_cnt counts 3 for 3 events when the macro is defined.
